// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec
//
// Execute-stage ALU with valid/ready handshakes on both sides. Logic,
// arithmetic and compare ops finish in one cycle. SLL/SRL use an iterative
// shifter that moves one bit per cycle, so a shift by n holds the block for
// n extra cycles. Only one operation is in flight at a time.
//
// Build option:
//   ALU_OVERFLOW_EN - when defined, adds the `ovf` output. `ovf` flags signed
//                     overflow on ADD/SUB and is registered with `result`.
//                     When undefined, neither the port nor the overflow
//                     logic exists.
//
// Parameters:
//   WIDTH - operand/result width (power of two, >= 8)
//   SHW   - shift-amount width, derived from WIDTH (leave at default)
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   in_valid  - alu_ctl/a/b are valid
//   in_ready  - block can accept an operation (registered)
//   alu_ctl   - 4-bit ALU control code
//   a         - operand A, shift source for SLL/SRL
//   b         - operand B, b[SHW-1:0] is the shift amount for SLL/SRL
//   out_valid - result is valid (registered)
//   out_ready - consumer accepts the result
//   result    - registered result
//   zero      - registered flag, result == 0
//   err       - registered flag, op code was undefined
//   ovf       - registered signed-overflow flag (ALU_OVERFLOW_EN only)
// ---------------------------------------------------------------------------
module alu_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    // ALU control codes
    localparam logic [3:0] OP_ADD = 4'b0111;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0000;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRL = 4'b0010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Registered state and outputs
    state_t           state_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             err_reg;
    logic             out_valid_reg;
    logic             in_ready_reg;
    logic [WIDTH-1:0] sreg_reg;    // working value of the iterative shifter
    logic [SHW-1:0]   count_reg;   // remaining shift steps
    logic             dir_reg;     // 1 = shift right (SRL), 0 = shift left
`ifdef ALU_OVERFLOW_EN
    logic             ovf_reg;
`endif

    // Single-cycle datapath
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] diff_next;
    logic [WIDTH-1:0] op_result_next;
    logic             op_err_next;
    logic             op_is_shift_next;
    logic [SHW-1:0]   shift_amt_next;
`ifdef ALU_OVERFLOW_EN
    logic             op_ovf_next;
`endif

    assign shift_amt_next = b[SHW-1:0];

    always_comb begin
        sum_next         = a + b;
        diff_next        = a - b;
        op_result_next   = '0;
        op_err_next      = 1'b0;
        op_is_shift_next = 1'b0;
        case (alu_ctl)
            OP_ADD: op_result_next = sum_next;
            OP_SUB: op_result_next = diff_next;
            OP_AND: op_result_next = a & b;
            OP_OR:  op_result_next = a | b;
            OP_XOR: op_result_next = a ^ b;
            OP_NOR: op_result_next = ~(a | b);
            // True signed compare; a-b sign alone would be wrong on overflow.
            OP_SLT: op_result_next = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            // A zero-amount shift returns `a` directly; non-zero amounts are
            // handled by the iterative shifter and never use this value.
            OP_SLL, OP_SRL: begin
                op_result_next   = a;
                op_is_shift_next = 1'b1;
            end
            default: op_err_next = 1'b1;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        op_ovf_next = 1'b0;
        if (alu_ctl == OP_ADD) begin
            // Same-sign operands producing a result of the other sign.
            op_ovf_next = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum_next[WIDTH-1] != a[WIDTH-1]);
        end else if (alu_ctl == OP_SUB) begin
            // Opposite-sign operands with the result sign flipped from a.
            op_ovf_next = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff_next[WIDTH-1] != a[WIDTH-1]);
        end
    end
`endif

    // One-bit shift network: each bit takes its neighbour, zero fill at ends.
    logic [WIDTH-1:0] shl_one_next;
    logic [WIDTH-1:0] shr_one_next;
    logic [WIDTH-1:0] shift_one_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shl_one_next[gi] = 1'b0;
                assign shr_one_next[gi] = sreg_reg[gi+1];
            end else if (gi == WIDTH-1) begin : g_msb
                assign shl_one_next[gi] = sreg_reg[gi-1];
                assign shr_one_next[gi] = 1'b0;
            end else begin : g_mid
                assign shl_one_next[gi] = sreg_reg[gi-1];
                assign shr_one_next[gi] = sreg_reg[gi+1];
            end
        end
    endgenerate

    assign shift_one_next = dir_reg ? shr_one_next : shl_one_next;

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
            sreg_reg      <= '0;
            count_reg     <= '0;
            dir_reg       <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            ovf_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    // in_ready comes up one cycle after reset releases, so
                    // acceptance is gated by the registered flag.
                    in_ready_reg <= 1'b1;
                    if (in_valid && in_ready_reg) begin
                        in_ready_reg <= 1'b0;
                        if (op_is_shift_next && (shift_amt_next != '0)) begin
                            sreg_reg  <= a;
                            count_reg <= shift_amt_next;
                            dir_reg   <= (alu_ctl == OP_SRL);
                            state_reg <= SHIFT;
                        end else begin
                            result_reg    <= op_result_next;
                            zero_reg      <= (op_result_next == '0);
                            err_reg       <= op_err_next;
`ifdef ALU_OVERFLOW_EN
                            ovf_reg       <= op_ovf_next;
`endif
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end

                SHIFT: begin
                    sreg_reg  <= shift_one_next;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == SHW'(1)) begin
                        result_reg    <= shift_one_next;
                        zero_reg      <= (shift_one_next == '0);
                        err_reg       <= 1'b0;
`ifdef ALU_OVERFLOW_EN
                        ovf_reg       <= 1'b0;
`endif
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end

                DONE: begin
                    // Outputs hold until the consumer takes the result.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign err       = err_reg;
`ifdef ALU_OVERFLOW_EN
    assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_exec
//
// Self-checking bench for alu_exec (WIDTH = 32). Directed scenarios from the
// test plan plus a randomized run checked against a behavioural model that
// computes results with plain arithmetic and whole-word shift operators.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_exec;

    localparam int W     = 32;
    localparam int LIMIT = 64;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         err;
`ifdef ALU_OVERFLOW_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_exec #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ctl  (alu_ctl),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .err      (err)
`ifdef ALU_OVERFLOW_EN
        ,
        .ovf      (ovf)
`endif
    );

    function automatic logic cur_ovf();
`ifdef ALU_OVERFLOW_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Behavioural reference: result, err, signed overflow and latency
    // (posedges from the accepting edge until out_valid is visible).
    function automatic void model(input logic [3:0] op, input logic [W-1:0] ma, mb,
                                  output logic [W-1:0] r, output logic e, o,
                                  output int lat);
        longint sa, sb, s;
        int n;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        n  = int'(mb % 32);
        r = '0; e = 1'b0; o = 1'b0; lat = 1;
        case (op)
            4'b0111: begin s = sa + sb; r = ma + mb; o = (s > SMAX) || (s < SMIN); end
            4'b0100: begin s = sa - sb; r = ma - mb; o = (s > SMAX) || (s < SMIN); end
            4'b0110: r = ma & mb;
            4'b0101: r = ma | mb;
            4'b0000: r = ma ^ mb;
            4'b0011: r = ~(ma | mb);
            4'b1000: r = W'(sa < sb);
            4'b0001: begin r = ma << n; lat = n + 1; end
            4'b0010: begin r = ma >> n; lat = n + 1; end
            default: e = 1'b1;
        endcase
    endfunction

    // Driver: waits for in_ready, presents one op, measures latency, holds
    // out_ready low for `hold` cycles (optionally with junk input traffic),
    // then completes the output handshake. Returns observations only.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] oa, ob,
                         input int hold, input bit junk,
                         output logic [W-1:0] r, output logic z, e, o,
                         output int lat, output bit busy_ok, stable_ok, released);
        int w;
        w = 0;
        busy_ok = 1'b1; stable_ok = 1'b1; released = 1'b0;
        while (!in_ready && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        alu_ctl = op; a = oa; b = ob; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < LIMIT) begin
            if (in_ready) busy_ok = 1'b0;
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                alu_ctl = 4'($urandom); a = $urandom; b = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        r = result; z = zero; e = err; o = cur_ovf();
        if (in_ready) busy_ok = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                in_valid = 1'b1;
                alu_ctl = 4'($urandom); a = $urandom; b = $urandom;
            end
            @(negedge clk);
            if (result !== r || zero !== z || err !== e || cur_ovf() !== o ||
                out_valid !== 1'b1 || in_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        released = (out_valid === 1'b0) && (in_ready === 1'b1);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctl = 4'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", result); end
        n_cmp++; if (zero !== 1'b0 || err !== 1'b0 || cur_ovf() !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: got zero=%b err=%b ovf=%b expected all 0", zero, err, cur_ovf());
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add();
        logic [W-1:0] r; logic z, e, o; int lat; bit bo, so, rl;
        do_op(4'b0111, 32'd5, 32'd7, 0, 1'b0, r, z, e, o, lat, bo, so, rl);
        n_cmp++; if (r !== 32'd12) begin n_bad++; $display("FAIL add_result: got %h expected %h", r, 32'd12); end
        n_cmp++; if (z !== 1'b0 || e !== 1'b0) begin n_bad++; $display("FAIL add_flags: got zero=%b err=%b expected 0 0", z, e); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL add_latency: got %0d expected 1", lat); end
        n_cmp++; if (!rl) begin n_bad++; $display("FAIL add_release: got 0 expected 1"); end
    endtask

    task automatic test_sub_zero_ovf();
        logic [W-1:0] r; logic z, e, o; int lat; bit bo, so, rl;
        do_op(4'b0100, 32'h1234, 32'h1234, 0, 1'b0, r, z, e, o, lat, bo, so, rl);
        n_cmp++; if (r !== '0) begin n_bad++; $display("FAIL sub_zero_result: got %h expected 0", r); end
        n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL sub_zero_flag: got %b expected 1", z); end
        do_op(4'b0111, 32'h7FFFFFFF, 32'd1, 0, 1'b0, r, z, e, o, lat, bo, so, rl);
        n_cmp++; if (r !== 32'h80000000) begin n_bad++; $display("FAIL add_ovf_result: got %h expected 80000000", r); end
`ifdef ALU_OVERFLOW_EN
        n_cmp++; if (o !== 1'b1) begin n_bad++; $display("FAIL add_ovf_flag: got %b expected 1", o); end
`endif
    endtask

    task automatic test_slt();
        logic [W-1:0] r; logic z, e, o; int lat; bit bo, so, rl;
        do_op(4'b1000, 32'hFFFFFFFF, 32'd1, 0, 1'b0, r, z, e, o, lat, bo, so, rl);
        n_cmp++; if (r !== 32'd1) begin n_bad++; $display("FAIL slt_neg_lt: got %h expected 1", r); end
        do_op(4'b1000, 32'd1, 32'hFFFFFFFF, 0, 1'b0, r, z, e, o, lat, bo, so, rl);
        n_cmp++; if (r !== 32'd0 || z !== 1'b1) begin n_bad++; $display("FAIL slt_swapped: got %h zero=%b expected 0 zero=1", r, z); end
    endtask

    task automatic test_shifts();
        logic [W-1:0] r; logic z, e, o; int lat; bit bo, so, rl;
        do_op(4'b0001, 32'd1, 32'd31, 0, 1'b0, r, z, e, o, lat, bo, so, rl);
        n_cmp++; if (r !== 32'h80000000) begin n_bad++; $display("FAIL sll31_result: got %h expected 80000000", r); end
        n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL sll31_latency: got %0d expected 32", lat); end
        n_cmp++; if (!bo) begin n_bad++; $display("FAIL sll31_in_ready_low: got 0 expected 1"); end
        do_op(4'b0010, 32'hCAFEF00D, 32'h0, 0, 1'b0, r, z, e, o, lat, bo, so, rl);
        n_cmp++; if (r !== 32'hCAFEF00D || lat !== 1) begin n_bad++; $display("FAIL srl0: got %h lat=%0d expected cafef00d lat=1", r, lat); end
        do_op(4'b0010, 32'h80000000, 32'h24, 0, 1'b0, r, z, e, o, lat, bo, so, rl);
        n_cmp++; if (r !== 32'h08000000) begin n_bad++; $display("FAIL srl4_result: got %h expected 08000000", r); end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL srl4_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] r; logic z, e, o; int lat; bit bo, so, rl; bit stray;
        do_op(4'b1111, $urandom, $urandom, 5, 1'b1, r, z, e, o, lat, bo, so, rl);
        n_cmp++; if (e !== 1'b1 || r !== '0) begin n_bad++; $display("FAIL undef_err: got err=%b result=%h expected err=1 result=0", e, r); end
        n_cmp++; if (!so) begin n_bad++; $display("FAIL undef_hold_stable: got 0 expected 1"); end
        n_cmp++; if (!rl) begin n_bad++; $display("FAIL undef_release: got 0 expected 1"); end
        // Junk pulses during DONE must not have started a hidden operation.
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        n_cmp++; if (stray) begin n_bad++; $display("FAIL ignored_in_valid: got stray out_valid expected none"); end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] r; logic z, e, o; int lat; bit bo, so, rl; bit seen;
        int w;
        w = 0;
        while (!in_ready && w < LIMIT) begin @(negedge clk); w++; end
        alu_ctl = 4'b0001; a = 32'h0000_00F3; b = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL midrst_handshake: got out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready);
        end
        n_cmp++; if (result !== '0 || zero !== 1'b0 || err !== 1'b0 || cur_ovf() !== 1'b0) begin
            n_bad++; $display("FAIL midrst_outputs: got result=%h zero=%b err=%b expected 0 0 0", result, zero, err);
        end
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL midrst_no_valid: got out_valid pulse expected none"); end
        do_op(4'b0111, 32'd100, 32'd23, 0, 1'b0, r, z, e, o, lat, bo, so, rl);
        n_cmp++; if (r !== 32'd123 || lat !== 1) begin n_bad++; $display("FAIL midrst_next_add: got %h lat=%0d expected 0000007b lat=1", r, lat); end
    endtask

    task automatic test_random();
        logic [W-1:0] r, er, ra, rb; logic z, e, o, ee, eo; int lat, elat; bit bo, so, rl;
        logic [3:0] op;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            model(op, ra, rb, er, ee, eo, elat);
            do_op(op, ra, rb, $urandom_range(0, 2), 1'b1, r, z, e, o, lat, bo, so, rl);
            n_cmp++; if (r !== er || e !== ee || z !== (er == '0)) begin
                n_bad++; $display("FAIL rand_result op=%b a=%h b=%h: got %h err=%b zero=%b expected %h err=%b zero=%b",
                                  op, ra, rb, r, e, z, er, ee, (er == '0));
            end
            n_cmp++; if (lat !== elat) begin n_bad++; $display("FAIL rand_latency op=%b b=%h: got %0d expected %0d", op, rb, lat, elat); end
            n_cmp++; if (!bo || !so || !rl) begin
                n_bad++; $display("FAIL rand_handshake op=%b: got busy=%b stable=%b release=%b expected 1 1 1", op, bo, so, rl);
            end
`ifdef ALU_OVERFLOW_EN
            n_cmp++; if (o !== eo) begin n_bad++; $display("FAIL rand_ovf op=%b a=%h b=%h: got %b expected %b", op, ra, rb, o, eo); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_zero_ovf();
        test_slt();
        test_shifts();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
